bit_serial_subtractor: RTL and testbench



---
 rtl/bit_serial_subtractor.sv | 108 ++++++++++
 tb/tb_bit_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtract/negate unit: one difference bit per clock, LSB first,
// with a single borrow flip-flop; operands and results move over valid/ready.
module bit_serial_subtractor #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_in_minuend,
   input  logic [WIDTH-1:0] io_in_subtrahend,
   input  logic             io_in_negate,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_out_diff,
   output logic             io_out_borrow,
   output logic             io_out_negative
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             borrow;
   logic [CW-1:0]    count;

   logic             accept;
   logic             a0;
   logic             b0;
   logic             d;
   logic             borrow_next;

   assign accept      = io_in_valid && (state == IDLE);
   assign a0          = a_sr[0];
   assign b0          = b_sr[0];
   assign d           = a0 ^ b0 ^ borrow;
   assign borrow_next = (~a0 & b0) | (~a0 & borrow) | (b0 & borrow);

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (io_in_valid) state_next = SHIFT;
         SHIFT:   if (count == LAST_COUNT) state_next = DONE;
         DONE:    if (io_out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Handshake outputs decoded from state
   always_comb begin
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      case (state)
         IDLE:    io_in_ready  = 1'b1;
         DONE:    io_out_valid = 1'b1;
         default: ;
      endcase
   end

   // Datapath: r_sr fills from the top, so after WIDTH shifts bit 0 holds the LSB
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         borrow <= 1'b0;
         count  <= '0;
      end else if (accept) begin
         a_sr   <= io_in_negate ? '0 : io_in_minuend;
         b_sr   <= io_in_subtrahend;
         r_sr   <= '0;
         borrow <= 1'b0;
         count  <= '0;
      end else if (state == SHIFT) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         r_sr   <= {d, r_sr[WIDTH-1:1]};
         borrow <= borrow_next;
         count  <= count + 1'b1;
      end
   end

   // Result registers are held after DONE until the next acceptance clears them
   assign io_out_diff     = r_sr;
   assign io_out_borrow   = borrow;
   assign io_out_negative = r_sr[WIDTH-1];

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor: directed cases, backpressure,
// asynchronous reset and a randomized regression against an arithmetic model.
module tb_bit_serial_subtractor;

   localparam int W = 32;

   logic         clock;
   logic         reset;
   logic         io_in_valid;
   logic         io_in_ready;
   logic [W-1:0] io_in_minuend;
   logic [W-1:0] io_in_subtrahend;
   logic         io_in_negate;
   logic         io_out_valid;
   logic         io_out_ready;
   logic [W-1:0] io_out_diff;
   logic         io_out_borrow;
   logic         io_out_negative;

   int checks = 0;
   int errors = 0;

   bit_serial_subtractor #(.WIDTH(W)) dut (
      .clock            (clock),
      .reset            (reset),
      .io_in_valid      (io_in_valid),
      .io_in_ready      (io_in_ready),
      .io_in_minuend    (io_in_minuend),
      .io_in_subtrahend (io_in_subtrahend),
      .io_in_negate     (io_in_negate),
      .io_out_valid     (io_out_valid),
      .io_out_ready     (io_out_ready),
      .io_out_diff      (io_out_diff),
      .io_out_borrow    (io_out_borrow),
      .io_out_negative  (io_out_negative)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: plain modular arithmetic, borrow as unsigned comparison
   function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic neg, output logic [W-1:0] d,
                                   output logic br, output logic ng);
      logic [W-1:0] m;
      m  = neg ? '0 : a;
      d  = m - b;
      br = (m < b);
      ng = d[W-1];
   endfunction

   // Result bundle captured by run_op
   logic [W-1:0] r_diff;
   logic         r_borrow;
   logic         r_neg;
   int           r_edges;
   bit           r_accept_ready;
   bit           r_busy_ok;
   bit           r_stable_ok;
   bit           r_ready_after;
   bit           r_valid_after;
   bit           r_held_ok;

   // Drives one operation end to end and records what the DUT showed
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic neg,
                         input int stall, input bit pulse);
      @(negedge clock);
      io_in_valid      = 1'b1;
      io_in_minuend    = a;
      io_in_subtrahend = b;
      io_in_negate     = neg;
      io_out_ready     = 1'b0;
      r_accept_ready   = io_in_ready;
      @(posedge clock);
      #1;
      io_in_valid      = 1'b0;
      io_in_minuend    = $urandom;
      io_in_subtrahend = $urandom;
      io_in_negate     = $urandom_range(0, 1);
      r_edges   = 0;
      r_busy_ok = 1'b1;
      do begin
         @(posedge clock);
         r_edges++;
         #1;
         io_in_valid = pulse && (r_edges >= 3) && (r_edges <= 6);
         if (pulse) begin
            io_in_minuend    = $urandom;
            io_in_subtrahend = $urandom;
            io_in_negate     = $urandom_range(0, 1);
         end
         @(negedge clock);
         if (io_in_ready) r_busy_ok = 1'b0;
      end while (!io_out_valid && r_edges < 100);
      io_in_valid = 1'b0;
      r_diff      = io_out_diff;
      r_borrow    = io_out_borrow;
      r_neg       = io_out_negative;
      r_stable_ok = 1'b1;
      repeat (stall) begin
         @(negedge clock);
         if (io_out_diff !== r_diff || io_out_borrow !== r_borrow ||
             io_out_negative !== r_neg || io_out_valid !== 1'b1 || io_in_ready !== 1'b0)
            r_stable_ok = 1'b0;
      end
      io_out_ready = 1'b1;
      @(posedge clock);
      #1;
      io_out_ready = 1'b0;
      @(negedge clock);
      r_ready_after = io_in_ready;
      r_valid_after = io_out_valid;
      r_held_ok     = (io_out_diff === r_diff) && (io_out_borrow === r_borrow);
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      io_in_valid      = 1'b0;
      io_in_minuend    = '0;
      io_in_subtrahend = '0;
      io_in_negate     = 1'b0;
      io_out_ready     = 1'b0;
      repeat (2) @(negedge clock);
      checks++;
      if (io_out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", io_out_valid);
      end
      checks++;
      if (io_in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", io_in_ready);
      end
      checks++;
      if ({io_out_diff, io_out_borrow, io_out_negative} !== '0) begin
         errors++; $display("FAIL reset_result: got diff=%h borrow=%b neg=%b expected all 0",
                            io_out_diff, io_out_borrow, io_out_negative);
      end
      reset = 1'b0;
      $display("reset: released");
   endtask

   // Directed operation plus full comparison against the model
   task automatic test_directed(input string name, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic neg);
      logic [W-1:0] ed;
      logic         eb;
      logic         en;
      ref_sub(a, b, neg, ed, eb, en);
      run_op(a, b, neg, 2, 1'b0);
      $display("%s: a=%h b=%h neg=%0d -> diff=%h borrow=%0d negative=%0d edges=%0d",
               name, a, b, neg, r_diff, r_borrow, r_neg, r_edges);
      checks++;
      if (r_diff !== ed) begin
         errors++; $display("FAIL %s_diff: got %h expected %h", name, r_diff, ed);
      end
      checks++;
      if (r_borrow !== eb || r_neg !== en) begin
         errors++; $display("FAIL %s_flags: got borrow=%b neg=%b expected borrow=%b neg=%b",
                            name, r_borrow, r_neg, eb, en);
      end
      checks++;
      if (r_edges !== W) begin
         errors++; $display("FAIL %s_latency: got %0d edges expected %0d", name, r_edges, W);
      end
      checks++;
      if (!r_accept_ready || !r_busy_ok || !r_ready_after || r_valid_after) begin
         errors++; $display("FAIL %s_handshake: got accept=%0d busy_ok=%0d ready_after=%0d valid_after=%0d expected 1 1 1 0",
                            name, r_accept_ready, r_busy_ok, r_ready_after, r_valid_after);
      end
   endtask

   task automatic test_basic();
      test_directed("sub_5_3", 32'd5, 32'd3, 1'b0);
      test_directed("sub_3_5", 32'd3, 32'd5, 1'b0);
      test_directed("sub_min_1", 32'h8000_0000, 32'd1, 1'b0);
   endtask

   task automatic test_negate();
      test_directed("neg_1", 32'h1234_5678, 32'd1, 1'b1);
      test_directed("neg_0", 32'hDEAD_BEEF, 32'd0, 1'b1);
      test_directed("neg_min", 32'h0000_0042, 32'h8000_0000, 1'b1);
   endtask

   task automatic test_backpressure();
      run_op(32'h0000_1000, 32'h0000_0001, 1'b0, 10, 1'b1);
      $display("backpressure: diff=%h borrow=%0d stable=%0d ready_after=%0d",
               r_diff, r_borrow, r_stable_ok, r_ready_after);
      checks++;
      if (r_diff !== 32'h0000_0FFF || r_borrow !== 1'b0) begin
         errors++; $display("FAIL bp_result: got diff=%h borrow=%b expected 00000fff 0", r_diff, r_borrow);
      end
      checks++;
      if (!r_stable_ok) begin
         errors++; $display("FAIL bp_stable: got unstable outputs or ready during stall expected stable");
      end
      checks++;
      if (!r_ready_after || r_valid_after || !r_held_ok) begin
         errors++; $display("FAIL bp_release: got ready=%0d valid=%0d held=%0d expected 1 0 1",
                            r_ready_after, r_valid_after, r_held_ok);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      io_in_valid      = 1'b1;
      io_in_minuend    = 32'hFFFF_0000;
      io_in_subtrahend = 32'h0000_1234;
      io_in_negate     = 1'b0;
      @(posedge clock);
      #1;
      io_in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      $display("async_reset: valid=%0d diff=%h ready=%0d", io_out_valid, io_out_diff, io_in_ready);
      checks++;
      if (io_out_valid !== 1'b0 || io_out_diff !== '0 || io_out_borrow !== 1'b0) begin
         errors++; $display("FAIL async_reset_clear: got valid=%b diff=%h borrow=%b expected 0 0 0",
                            io_out_valid, io_out_diff, io_out_borrow);
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
         errors++; $display("FAIL async_reset_release: got ready=%b valid=%b expected 1 0",
                            io_in_ready, io_out_valid);
      end
      test_directed("after_reset_7_7", 32'd7, 32'd7, 1'b0);
   endtask

   task automatic test_random(input int n);
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         neg;
      logic [W-1:0] ed;
      logic         eb;
      logic         en;
      int           bad;
      for (int i = 0; i < n; i++) begin
         a   = $urandom;
         b   = $urandom;
         if (i % 8 == 0) b = a;
         neg = $urandom_range(0, 1);
         ref_sub(a, b, neg, ed, eb, en);
         run_op(a, b, neg, $urandom_range(0, 3), bit'($urandom_range(0, 1)));
         $display("op %0d: a=%h b=%h neg=%0d diff=%h borrow=%0d edges=%0d",
                  i, a, b, neg, r_diff, r_borrow, r_edges);
         bad = 0;
         checks++;
         if (r_diff !== ed || r_borrow !== eb || r_neg !== en) begin
            errors++; bad = 1;
            $display("FAIL rand_%0d_result: got diff=%h borrow=%b neg=%b expected diff=%h borrow=%b neg=%b",
                     i, r_diff, r_borrow, r_neg, ed, eb, en);
         end
         checks++;
         if (r_edges !== W || !r_busy_ok || !r_stable_ok || !r_ready_after) begin
            errors++; bad = 1;
            $display("FAIL rand_%0d_timing: got edges=%0d busy_ok=%0d stable=%0d ready_after=%0d expected %0d 1 1 1",
                     i, r_edges, r_busy_ok, r_stable_ok, r_ready_after, W);
         end
         if (bad != 0 && errors > 20) break;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negate();
      test_backpressure();
      test_async_reset();
      test_random(1000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
